// File: rtl/csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// csa_accum_ctrl
//
// Multi-operand adder that takes NOPS operands one at a time and folds each
// into a carry-save pair (sreg, creg) through a single WIDTH-bit 3:2
// compressor. After the last operand it resolves sreg + creg + ci in one
// ripple add and holds the result until the consumer takes it.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      begin an operation (only honoured while idle)
//   ci         carry-in, captured on the cycle start is honoured
//   op         operand data
//   op_valid   operand present
//   op_ready   controller accepts an operand this cycle
//   s          result sum
//   co         carry out of the final resolve add
//   res_valid  s/co valid
//   res_ready  consumer accepts the result
//   busy       high whenever the controller is not idle
// ---------------------------------------------------------------------------
module csa_accum_ctrl #(
    parameter int WIDTH = 7,
    parameter int NOPS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ci,
    input  logic [WIDTH-1:0] op,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    localparam int CW = $clog2(NOPS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NOPS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] creg;
    logic [CW-1:0]    count;
    logic             ci_r;
    logic [WIDTH-1:0] maj;
    logic             accept;

    // An operand is consumed only on a real handshake while accumulating.
    assign accept = (state == ACCUM) && op_valid;

    // Bitwise majority of the three compressor inputs; this becomes the
    // carry vector once shifted up by one place.
    assign maj = (sreg & creg) | (sreg & op) | (creg & op);

    // State register. Reset from any state drops whatever was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. RESOLVE always lasts exactly one cycle, and the
    // operation ends when the NOPS-th operand is accepted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (accept && (count == LAST_IDX)) begin
                    state_next = RESOLVE;
                end
            end
            RESOLVE: begin
                state_next = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and status outputs are pure decodes of the state, so they
    // read as zero straight out of reset.
    always_comb begin
        op_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE:    busy      = 1'b0;
            ACCUM:   op_ready  = 1'b1;
            RESOLVE: op_ready  = 1'b0;
            DONE:    res_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // Datapath. The carry vector loses its top bit on every fold, so co
    // reflects the truncated carry-save form rather than true overflow.
    // s/co only change in RESOLVE, which keeps them stable throughout DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg  <= '0;
            creg  <= '0;
            count <= '0;
            ci_r  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg  <= '0;
                        creg  <= '0;
                        count <= '0;
                        ci_r  <= ci;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        sreg  <= sreg ^ creg ^ op;
                        creg  <= {maj[WIDTH-2:0], 1'b0};
                        count <= count + 1'b1;
                    end
                end
                RESOLVE: begin
                    {co, s} <= {1'b0, sreg} + {1'b0, creg} + {{WIDTH{1'b0}}, ci_r};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csa_accum_ctrl
//
// Drives whole operations into csa_accum_ctrl, pushes the modelled result
// onto a scoreboard queue when each operation starts, and lets a monitor pop
// and compare whenever the result handshake happens.
// ---------------------------------------------------------------------------
module tb_csa_accum_ctrl;

    localparam int WIDTH = 7;
    localparam int NOPS  = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             ci;
    logic [WIDTH-1:0] op;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             res_valid;
    logic             res_ready;
    logic             busy;

    int checkCount = 0;
    int passCount  = 0;

    logic [WIDTH:0] expQ[$];

    logic [WIDTH:0] heldRes;
    bit             heldOk = 0;

    logic [WIDTH-1:0] opsA [NOPS];

    csa_accum_ctrl #(.WIDTH(WIDTH), .NOPS(NOPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ci        (ci),
        .op        (op),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .s         (s),
        .co        (co),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference model: the carry-save recurrence followed by the resolve add.
    function automatic logic [WIDTH:0] modelResult(input logic ciIn,
                                                   input logic [WIDTH-1:0] ops [NOPS]);
        logic [WIDTH-1:0] sv;
        logic [WIDTH-1:0] cv;
        logic [WIDTH-1:0] t;
        logic [WIDTH-1:0] m;
        sv = '0;
        cv = '0;
        for (int i = 0; i < NOPS; i++) begin
            t  = sv ^ cv ^ ops[i];
            m  = (sv & cv) | (sv & ops[i]) | (cv & ops[i]);
            cv = m << 1;
            sv = t;
        end
        return {1'b0, sv} + {1'b0, cv} + {{WIDTH{1'b0}}, ciIn};
    endfunction

    // Monitor: pops the scoreboard on every result handshake and checks that
    // s/co do not move while the result is waiting.
    always @(negedge clk) begin
        logic [WIDTH:0] expRes;
        if (res_valid) begin
            if (heldOk) begin
                checkOutput("holdStable", {23'd0, co, s}, {23'd0, heldRes});
            end
            heldRes = {co, s};
            heldOk  = 1;
            if (res_ready) begin
                heldOk = 0;
                if (expQ.size() == 0) begin
                    checkOutput("sbUnexpected", 1, 0);
                end else begin
                    expRes = expQ.pop_front();
                    checkOutput("resultS",  {25'd0, s},  {25'd0, expRes[WIDTH-1:0]});
                    checkOutput("resultCo", {31'd0, co}, {31'd0, expRes[WIDTH]});
                end
            end
        end else begin
            heldOk = 0;
        end
    end

    // One complete operation. Entered and left at posedge+1; start is raised
    // immediately so back-to-back calls restart right after a handshake.
    task automatic applyStimulus(input logic ciIn, input logic [WIDTH-1:0] ops [NOPS],
                                 input bit randomValid, input bit pulseStart,
                                 input int holdCycles);
        int  idx;
        int  cyc;
        int  readyCycles;
        bit  acc;
        start     = 1'b1;
        ci        = ciIn;
        op_valid  = 1'b1;
        op        = ops[0];
        res_ready = (holdCycles == 0);
        expQ.push_back(modelResult(ciIn, ops));
        @(negedge clk);
        checkOutput("idleBusy",    {31'd0, busy},      0);
        checkOutput("idleOpReady", {31'd0, op_ready},  0);
        checkOutput("idleResVal",  {31'd0, res_valid}, 0);
        @(posedge clk); #1;
        start = 1'b0;
        ci    = ~ciIn;
        idx = 0;
        cyc = 0;
        readyCycles = 0;
        while (idx < NOPS && cyc < 200) begin
            op_valid = (randomValid && cyc < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
            op       = ops[idx];
            start    = (pulseStart && cyc == 2);
            @(negedge clk);
            if (op_ready) readyCycles++;
            acc = op_ready && op_valid;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        checkOutput("accumDone", idx, NOPS);
        checkOutput("readyCycles", readyCycles, cyc);
        start    = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        checkOutput("resolveResVal",  {31'd0, res_valid}, 0);
        checkOutput("resolveOpReady", {31'd0, op_ready},  0);
        checkOutput("resolveBusy",    {31'd0, busy},      1);
        @(negedge clk);
        checkOutput("doneResVal", {31'd0, res_valid}, 1);
        if (holdCycles > 0) begin
            repeat (holdCycles) @(posedge clk);
            #1;
            checkOutput("heldResVal", {31'd0, res_valid}, 1);
            res_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] opsOne   [NOPS];
        logic [WIDTH-1:0] opsMax   [NOPS];
        logic [WIDTH-1:0] opsCarry [NOPS];
        for (int i = 0; i < NOPS; i++) begin
            opsOne[i]   = 7'd1;
            opsMax[i]   = 7'd127;
            opsCarry[i] = 7'd0;
        end
        opsCarry[6] = 7'd96;
        opsCarry[7] = 7'd32;

        rst       = 1'b1;
        start     = 1'b0;
        ci        = 1'b0;
        op        = '0;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstBusy",    {31'd0, busy},      0);
        checkOutput("rstOpReady", {31'd0, op_ready},  0);
        checkOutput("rstResVal",  {31'd0, res_valid}, 0);
        checkOutput("rstS",       {25'd0, s},         0);
        checkOutput("rstCo",      {31'd0, co},        0);
        @(posedge clk); #1;

        $display("[TB] all ones, ci=0");
        applyStimulus(1'b0, opsOne, 0, 0, 0);
        $display("[TB] all 127, ci=1");
        applyStimulus(1'b1, opsMax, 0, 0, 0);
        $display("[TB] carry-save overflow into co");
        applyStimulus(1'b0, opsCarry, 0, 0, 0);
        $display("[TB] stalls, start during accumulate, result backpressure");
        applyStimulus(1'b0, opsOne, 1, 1, 5);

        $display("[TB] reset mid-accumulate");
        start    = 1'b1;
        ci       = 1'b0;
        @(posedge clk); #1;
        start    = 1'b0;
        op       = 7'd1;
        op_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst      = 1'b1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abortBusy",    {31'd0, busy},      0);
        checkOutput("abortOpReady", {31'd0, op_ready},  0);
        checkOutput("abortResVal",  {31'd0, res_valid}, 0);
        @(posedge clk); #1;
        applyStimulus(1'b1, opsOne, 0, 0, 0);

        $display("[TB] back-to-back random operations");
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NOPS; i++) opsA[i] = 7'($urandom_range(0, 127));
            applyStimulus(1'($urandom_range(0, 1)), opsA, k == 1, 0, k);
        end

        repeat (3) @(posedge clk);
        checkOutput("sbDrained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
